// File: rtl/mpu_fault_unit.sv
// MPU fault consumer: aligns the access stream to the fault pulse, records the first
// fault, counts overflows and raises irq_req. Optional MPU_FAULT_STAMP_EN adds a cycle stamp.
module mpu_fault_unit #(
  parameter logic [11:0] CsrBase    = 12'h430,
  parameter int unsigned AlignDelay = 1,
  parameter int unsigned OvfWidth   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_fault,
  input  logic [15:0] addr,
  input  logic [6:0]  op,
  input  logic [3:0]  id,
  input  logic        irq_ack,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic        csr_write,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        irq_req
);

  localparam logic [11:0] A_STATUS = CsrBase;
  localparam logic [11:0] A_ADDR   = CsrBase + 12'd1;
  localparam logic [11:0] A_CTRL   = CsrBase + 12'd2;
  localparam logic [11:0] A_STAMP  = CsrBase + 12'd3;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [26:0] pipe [AlignDelay];
  logic [26:0] pipe_out;

  logic                valid;
  logic                overflow;
  logic                is_store;
  logic [3:0]          rec_id;
  logic [15:0]         rec_addr;
  logic [OvfWidth-1:0] ovf_count;
  logic                irq_en, irq_en_nxt;

  logic clear, ctrl_wr, capture, overflow_hit;
  logic [30:0] unused_wdata;

  assign unused_wdata = csr_wdata[31:1];
  assign pipe_out     = pipe[AlignDelay-1];
  assign clear        = csr_enable && csr_write && (csr_addr == A_STATUS) && csr_wdata[0];
  assign ctrl_wr      = csr_enable && csr_write && (csr_addr == A_CTRL);
  // A clear in the same cycle as a fault frees the record, so the fault starts afresh.
  assign capture      = mem_fault && ((state == IDLE) || clear);
  assign overflow_hit = mem_fault && !capture;
  assign irq_en_nxt   = ctrl_wr ? csr_wdata[0] : irq_en;

  always_comb begin
    state_nxt = state;
    if (capture)
      state_nxt = PENDING;
    else if (clear)
      state_nxt = IDLE;
    else if ((state == PENDING) && irq_ack)
      state_nxt = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < AlignDelay; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {id, op, addr};
      for (int unsigned i = 1; i < AlignDelay; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      is_store  <= 1'b0;
      rec_id    <= '0;
      rec_addr  <= '0;
      ovf_count <= '0;
      irq_en    <= 1'b1;
      irq_req   <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_en  <= irq_en_nxt;
      irq_req <= (state_nxt == PENDING) && irq_en_nxt;
      if (capture) begin
        valid     <= 1'b1;
        overflow  <= 1'b0;
        ovf_count <= '0;
        rec_addr  <= pipe_out[15:0];
        is_store  <= (pipe_out[22:16] == OP_STORE);
        rec_id    <= pipe_out[26:23];
      end else if (clear) begin
        valid     <= 1'b0;
        overflow  <= 1'b0;
        ovf_count <= '0;
        rec_addr  <= '0;
        is_store  <= 1'b0;
        rec_id    <= '0;
      end else if (overflow_hit) begin
        overflow <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + OvfWidth'(1);
      end
    end
  end

`ifdef MPU_FAULT_STAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] stamp;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      stamp     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (capture)
        stamp <= cycle_cnt;
      else if (clear)
        stamp <= '0;
    end
  end
`else
  logic [31:0] stamp;
  assign stamp = '0;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_STATUS: begin
        csr_rdata[0]    = valid;
        csr_rdata[1]    = overflow;
        csr_rdata[2]    = is_store;
        csr_rdata[7:4]  = rec_id;
        csr_rdata[15:8] = 8'(ovf_count);
      end
      A_ADDR:  csr_rdata = {16'h0, rec_addr};
      A_CTRL:  csr_rdata = {31'h0, irq_en};
      A_STAMP: csr_rdata = stamp;
      default: csr_rdata = '0;
    endcase
  end

endmodule
